reg_hazard_scoreboard: RTL
==========================

Name: reg_hazard_scoreboard

Overview:
- Parametrised ID-stage register hazard tracker for the in-order MIPS pipeline.
- Holds one entry per downstream stage (EX, MEM, WB, ...) recording each in-flight instruction's destination register and the stage at which its result becomes forwardable.
- Each cycle it compares the ID instruction's source registers against these entries and drives per-port forwarding selects and a single load-use stall.
- Sits between ID decode (read/write enables and addresses) and the operand bypass muxes.

Parameters:
- REG_ADDR_WIDTH, 5: register address width.
- READ_PORTS, 2: number of ID source operands checked.
- PIPE_DEPTH, 3: number of tracked downstream stages (stage 1 = EX).
- LOAD_READY_STAGE, 2: first stage at which a load result is forwardable. Must satisfy 1 < value <= PIPE_DEPTH.
- SEL_WIDTH, 2: forwarding select width. Must satisfy 2^SEL_WIDTH > PIPE_DEPTH.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: asynchronous, active-low reset.
- id_valid, input, 1: ID holds a real instruction.
- id_read_en, input, READ_PORTS: per-port source read enable.
- id_read_addr, input, READ_PORTS*REG_ADDR_WIDTH: source addresses; port p at bits [p*W +: W].
- id_write_en, input, 1: instruction writes a GPR.
- id_write_addr, input, REG_ADDR_WIDTH: destination register.
- id_is_load, input, 1: destination is a memory-load result.
- hold, input, 1: downstream freeze (memory wait); tracker does not advance.
- flush, input, 1: discard all in-flight entries (exception/eret).
- stall, output, 1: ID must be held and a bubble inserted into EX.
- fwd_sel, output, READ_PORTS*SEL_WIDTH: per port, 0 = register file, k = forward from stage k.
- pending_cnt, output, SEL_WIDTH+1: number of valid entries.

Behaviour:
- Entry k (1..PIPE_DEPTH) holds: valid, addr, rdy_stage. rdy_stage is 1 for non-load writes and LOAD_READY_STAGE for loads.
- Entry k is "ready" when k >= rdy_stage.
- Reset (rst low, asynchronous):
  - All entries invalid.
  - pending_cnt=0, stall=0, fwd_sel=0.
  - Takes effect mid-operation immediately, with no partial shift.
- Combinational match, per port p, when id_valid and id_read_en[p] and addr_p != 0:
  - Find the lowest-index (youngest) valid entry with addr == addr_p.
  - If it is ready: fwd_sel[p] = its index.
  - If it is not ready: port p is hazarded and fwd_sel[p] = 0.
  - If there is no match: fwd_sel[p] = 0.
  - Older matches are ignored whenever a younger match exists.
- Ports with the read enable off, or reading address 0: fwd_sel=0, never hazarded.
- stall = OR of port hazards, gated to 0 when flush is asserted. stall depends only on current state and ID inputs (zero latency).
- Sequential update, priority flush > hold > advance:
  - flush: all entries invalid next cycle, regardless of hold.
  - hold (no flush): all entries retain value; stall and fwd_sel still re-evaluate combinationally.
  - advance: entry[k] <= entry[k-1] for k >= 2, and the oldest entry drops out. entry[1] is loaded with {1, id_write_addr, rdy} when id_valid && !stall && id_write_en && id_write_addr != 0; otherwise entry[1] is invalid (bubble).
- Every cycle an entry spends shifting raises its k; a stalled consumer re-evaluates next cycle and picks up the now-ready producer.
- pending_cnt is the registered popcount of valid entries, updated on the same edge as the entries.
- A write to $0 never creates an entry.
- Simultaneous hazard on both ports gives a single stall. Forwarding selects are independent per port.

Test Plan:
- ALU chain: addiu $3 then addu $4,$3,$3 back-to-back -> cycle 2: stall=0, both fwd_sel=1. Next cycle a dependent reader of $3 sees fwd_sel=2.
- Load-use: lw $5 then addu $6,$5,$0 -> stall=1 for exactly one cycle, bubble in EX. The following cycle: stall=0, fwd_sel[0]=2, fwd_sel[1]=0.
- Youngest wins: ori $7 (stage 2) and addiu $7 (stage 1) both pending, reader of $7 -> fwd_sel=1.
- $0 and disabled ports: lw $0, then a reader of $0 with read_en=0 on the other port -> stall=0, no entry created, pending_cnt unchanged.
- hold/flush: lw $8 pending with hold=1 for 3 cycles -> entries frozen and stall stays 1. Then flush=1 with hold=1 -> stall=0 that cycle, pending_cnt=0 next cycle.
- Reset mid-stream: pending_cnt=3, drop rst asynchronously between edges -> pending_cnt=0 and stall=0 immediately. After release, the first reader of $8 gets fwd_sel=0.

Source files
------------

// File: rtl/reg_hazard_scoreboard.sv
// ID-stage register hazard tracker: one entry per downstream stage, producing
// per-port forwarding selects and a single load-use stall for the in-order pipeline.
module reg_hazard_scoreboard #(
   parameter int REG_ADDR_WIDTH   = 5,
   parameter int READ_PORTS       = 2,
   parameter int PIPE_DEPTH       = 3,
   parameter int LOAD_READY_STAGE = 2,
   parameter int SEL_WIDTH        = 2
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic                                 id_valid_i,
   input  logic [READ_PORTS-1:0]                id_read_en_i,
   input  logic [READ_PORTS*REG_ADDR_WIDTH-1:0] id_read_addr_i,
   input  logic                                 id_write_en_i,
   input  logic [REG_ADDR_WIDTH-1:0]            id_write_addr_i,
   input  logic                                 id_is_load_i,
   input  logic                                 hold_i,
   input  logic                                 flush_i,
   output logic                                 stall_o,
   output logic [READ_PORTS*SEL_WIDTH-1:0]      fwd_sel_o,
   output logic [SEL_WIDTH:0]                   pending_cnt_o
);

   localparam logic [SEL_WIDTH-1:0] LoadRdy = SEL_WIDTH'(LOAD_READY_STAGE);
   localparam logic [SEL_WIDTH-1:0] AluRdy  = SEL_WIDTH'(1);

   // Entry k sits k stages past ID; index 1 is EX and the youngest producer.
   logic [PIPE_DEPTH:1]                     entryValid_q, entryValid_d;
   logic [PIPE_DEPTH:1][REG_ADDR_WIDTH-1:0] entryAddr_q, entryAddr_d;
   logic [PIPE_DEPTH:1][SEL_WIDTH-1:0]      entryRdy_q, entryRdy_d;
   logic [SEL_WIDTH:0]                      pendingCnt_q, pendingCnt_d;

   logic [READ_PORTS-1:0]           portHazard;
   logic [READ_PORTS*SEL_WIDTH-1:0] fwdSel;
   logic                            stall;
   logic                            allocate;

   always_comb begin
      logic [REG_ADDR_WIDTH-1:0] srcAddr;
      logic                      matchFound;
      logic                      matchReady;
      logic [SEL_WIDTH-1:0]      matchIdx;
      portHazard = '0;
      fwdSel     = '0;
      srcAddr    = '0;
      matchFound = 1'b0;
      matchReady = 1'b0;
      matchIdx   = '0;
      for (int p = 0; p < READ_PORTS; p++) begin
         srcAddr    = id_read_addr_i[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
         matchFound = 1'b0;
         matchReady = 1'b0;
         matchIdx   = '0;
         // Scan oldest to youngest so the youngest match overwrites older ones.
         for (int k = PIPE_DEPTH; k >= 1; k--) begin
            if (entryValid_q[k] && (entryAddr_q[k] == srcAddr)) begin
               matchFound = 1'b1;
               matchIdx   = SEL_WIDTH'(k);
               matchReady = (SEL_WIDTH'(k) >= entryRdy_q[k]);
            end
         end
         if (id_valid_i && id_read_en_i[p] && (srcAddr != '0) && matchFound) begin
            if (matchReady) begin
               fwdSel[p*SEL_WIDTH +: SEL_WIDTH] = matchIdx;
            end else begin
               portHazard[p] = 1'b1;
            end
         end
      end
   end

   assign stall    = (|portHazard) && !flush_i;
   assign allocate = id_valid_i && !stall && id_write_en_i && (id_write_addr_i != '0);

   always_comb begin
      entryValid_d = entryValid_q;
      entryAddr_d  = entryAddr_q;
      entryRdy_d   = entryRdy_q;
      if (flush_i) begin
         entryValid_d = '0;
      end else if (!hold_i) begin
         for (int k = PIPE_DEPTH; k >= 2; k--) begin
            entryValid_d[k] = entryValid_q[k-1];
            entryAddr_d[k]  = entryAddr_q[k-1];
            entryRdy_d[k]   = entryRdy_q[k-1];
         end
         entryValid_d[1] = allocate;
         entryAddr_d[1]  = id_write_addr_i;
         entryRdy_d[1]   = id_is_load_i ? LoadRdy : AluRdy;
      end
      pendingCnt_d = '0;
      for (int k = 1; k <= PIPE_DEPTH; k++) begin
         pendingCnt_d = pendingCnt_d + (SEL_WIDTH+1)'(entryValid_d[k]);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         entryValid_q <= '0;
         entryAddr_q  <= '0;
         entryRdy_q   <= '0;
         pendingCnt_q <= '0;
      end else begin
         entryValid_q <= entryValid_d;
         entryAddr_q  <= entryAddr_d;
         entryRdy_q   <= entryRdy_d;
         pendingCnt_q <= pendingCnt_d;
      end
   end

   assign stall_o       = stall;
   assign fwd_sel_o     = fwdSel;
   assign pending_cnt_o = pendingCnt_q;

endmodule
